// File: rtl/clk_monitor.sv
// clk_monitor: measures mon_clk high/low phase lengths in clk cycles and flags window errors.
// Define CLK_MON_STALL_EN to build the stopped-clock timeout; without it stall stays 0.
module clk_monitor #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned EXP_HIGH = 5,
   parameter int unsigned EXP_LOW  = 5,
   parameter int unsigned TOL      = 1,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mon_clk,
   input  logic             en,
   input  logic             err_clr,
   output logic [CNT_W-1:0] meas_high,
   output logic [CNT_W-1:0] meas_low,
   output logic             meas_valid,
   output logic             high_err,
   output logic             low_err,
   output logic             stall,
   output logic [7:0]       err_cnt
);

   localparam int unsigned ERR_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;
   localparam logic [CNT_W:0]   EXP_HIGH_W = (CNT_W+1)'(EXP_HIGH);
   localparam logic [CNT_W:0]   EXP_LOW_W  = (CNT_W+1)'(EXP_LOW);
   localparam logic [CNT_W:0]   TOL_W      = (CNT_W+1)'(TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_W  = CNT_W'(TIMEOUT);
`ifdef CLK_MON_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [2:0]       vld_q, vld_d;
   logic             rise_q, rise_d, fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] meas_high_q, meas_high_d, meas_low_q, meas_low_d;
   logic             meas_valid_q, meas_valid_d;
   logic             high_err_q, high_err_d, low_err_q, low_err_d;
   logic             stall_q, stall_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             edge_c, timeout_c, err_inc_c;

   function automatic logic out_of_window(input logic [CNT_W-1:0] m, input logic [CNT_W:0] exp_len);
      logic [CNT_W:0] m_w;
      logic [CNT_W:0] diff;
      m_w  = {1'b0, m};
      diff = (m_w > exp_len) ? (m_w - exp_len) : (exp_len - m_w);
      return (diff > TOL_W) || (m == CNT_MAX);
   endfunction

   // Synchronizer and edge detect; edges are masked until prev holds a real post-reset sample
   always_comb begin
      sync1_d = mon_clk;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      vld_d   = {vld_q[1:0], 1'b1};
      rise_d  = vld_q[2] & sync2_q & ~prev_q;
      fall_d  = vld_q[2] & ~sync2_q & prev_q;
   end

   assign edge_c    = rise_q | fall_q;
   assign timeout_c = STALL_EN && ((state_q == S_HIGH) || (state_q == S_LOW)) &&
                      !edge_c && (cnt_q == TIMEOUT_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_ARM;
            S_ARM:   if (rise_q) state_d = S_HIGH;
            S_HIGH:  if (fall_q) state_d = S_LOW;  else if (timeout_c) state_d = S_ARM;
            S_LOW:   if (rise_q) state_d = S_HIGH; else if (timeout_c) state_d = S_ARM;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d        = cnt_q;
      meas_high_d  = meas_high_q;
      meas_low_d   = meas_low_q;
      meas_valid_d = 1'b0;
      high_err_d   = 1'b0;
      low_err_d    = 1'b0;
      stall_d      = stall_q;

      if (state_q == S_IDLE)     cnt_d = '0;
      else if (edge_c)           cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);

      if (!en || (state_q == S_IDLE)) stall_d = 1'b0;
      else if (edge_c)                stall_d = 1'b0;
      else if (timeout_c)             stall_d = 1'b1;

      if (en && (state_q == S_HIGH) && fall_q) begin
         meas_high_d = cnt_q;
         high_err_d  = out_of_window(cnt_q, EXP_HIGH_W);
      end
      if (en && (state_q == S_LOW) && rise_q) begin
         meas_low_d   = cnt_q;
         meas_valid_d = 1'b1;
         low_err_d    = out_of_window(cnt_q, EXP_LOW_W);
      end

      // Error sources are mutually exclusive in any one cycle
      err_inc_c = high_err_d | low_err_d | (stall_d & ~stall_q);
      if (err_clr)                            err_cnt_d = ERR_W'(err_inc_c);
      else if (err_inc_c && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
      else                                    err_cnt_d = err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         prev_q       <= 1'b0;
         vld_q        <= '0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         cnt_q        <= '0;
         meas_high_q  <= '0;
         meas_low_q   <= '0;
         meas_valid_q <= 1'b0;
         high_err_q   <= 1'b0;
         low_err_q    <= 1'b0;
         stall_q      <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         vld_q        <= vld_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         cnt_q        <= cnt_d;
         meas_high_q  <= meas_high_d;
         meas_low_q   <= meas_low_d;
         meas_valid_q <= meas_valid_d;
         high_err_q   <= high_err_d;
         low_err_q    <= low_err_d;
         stall_q      <= stall_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign meas_high  = meas_high_q;
   assign meas_low   = meas_low_q;
   assign meas_valid = meas_valid_q;
   assign high_err   = high_err_q;
   assign low_err    = low_err_q;
   assign stall      = stall_q & STALL_EN;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: randomized and directed bench for clk_monitor against a phase-timing model.
`timescale 1ns/1ps
module tb_clk_monitor;

   localparam int CNT_W    = 16;
   localparam int EXP_HIGH = 5;
   localparam int EXP_LOW  = 5;
   localparam int TOL      = 1;
   localparam int TIMEOUT  = 64;
   localparam int MAXC     = 65535;
`ifdef CLK_MON_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             mon_clk;
   logic             en = 1'b0;
   logic             err_clr = 1'b0;
   logic [CNT_W-1:0] meas_high, meas_low;
   logic             meas_valid, high_err, low_err, stall;
   logic [7:0]       err_cnt;

   clk_monitor #(.CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .en(en), .err_clr(err_clr),
      .meas_high(meas_high), .meas_low(meas_low), .meas_valid(meas_valid),
      .high_err(high_err), .low_err(low_err), .stall(stall), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_on   = 1'b0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // mon_clk generator, driven on negedges so each level is sampled a whole number of clk cycles
   int hi_len = 5, lo_len = 5;
   bit gen_on = 1'b0, gen_rand = 1'b0;
   int last_rise_cyc = 0, last_fall_cyc = 0;

   function automatic int pick_len();
      if ($urandom_range(0, 39) == 0) return 70;
      return int'($urandom_range(1, 12));
   endfunction

   initial begin
      int h, l;
      mon_clk = 1'b0;
      forever begin
         if (gen_on) begin
            h = hi_len; l = lo_len;
            if (gen_rand) begin h = pick_len(); l = pick_len(); end
            mon_clk = 1'b1; last_rise_cyc = cyc + 1;
            repeat (h) @(negedge clk);
            mon_clk = 1'b0; last_fall_cyc = cyc + 1;
            repeat (l) @(negedge clk);
         end else begin
            @(negedge clk);
         end
      end
   end

   // Model: an edge sampled at cycle k is acted on at cycle k+3; a phase is the gap between acted edges
   typedef enum int {P_IDLE, P_ARM, P_HIGH, P_LOW} phase_e;
   phase_e m_ph;
   int     samp[$];
   int     m_k, m_last, m_mh, m_ml, m_err, m_len;
   bit     m_valid, m_herr, m_lerr, m_stall, m_ev, m_rise, m_inc;

   function automatic bit bad(input int len, input int expv);
      int d;
      d = (len > expv) ? (len - expv) : (expv - len);
      return (d > TOL) || (len >= MAXC);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = P_IDLE; samp = '{-1, -1, -1, -1, -1};
         m_k = 0; m_last = 0; m_mh = 0; m_ml = 0; m_err = 0;
         m_valid = 0; m_herr = 0; m_lerr = 0; m_stall = 0;
      end else begin
         m_k++;
         samp.push_front(int'(mon_clk));
         void'(samp.pop_back());
         m_ev   = (samp[3] >= 0) && (samp[4] >= 0) && (samp[3] != samp[4]);
         m_rise = m_ev && (samp[3] == 1);
         m_len  = (m_k - m_last > MAXC) ? MAXC : (m_k - m_last);
         m_valid = 0; m_herr = 0; m_lerr = 0; m_inc = 0;
         if (!en) begin
            m_ph = P_IDLE; m_stall = 0;
         end else begin
            case (m_ph)
               P_IDLE: m_ph = P_ARM;
               P_ARM: if (m_ev) begin
                  m_stall = 0;
                  if (m_rise) m_ph = P_HIGH;
               end
               P_HIGH: if (m_ev && !m_rise) begin
                  m_mh = m_len; m_herr = bad(m_len, EXP_HIGH); m_inc = m_herr; m_ph = P_LOW;
               end else if (!m_ev && STALL_EN && m_len == TIMEOUT) begin
                  m_stall = 1; m_inc = 1; m_ph = P_ARM;
               end
               P_LOW: if (m_rise) begin
                  m_ml = m_len; m_valid = 1; m_lerr = bad(m_len, EXP_LOW); m_inc = m_lerr; m_ph = P_HIGH;
               end else if (!m_ev && STALL_EN && m_len == TIMEOUT) begin
                  m_stall = 1; m_inc = 1; m_ph = P_ARM;
               end
               default: m_ph = P_IDLE;
            endcase
            if (m_ev) m_last = m_k;
         end
         m_err = (err_clr ? 0 : m_err) + int'(m_inc);
         if (m_err > 255) m_err = 255;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("meas_high", meas_high, m_mh);
         check("meas_low", meas_low, m_ml);
         check("meas_valid", meas_valid, m_valid);
         check("high_err", high_err, m_herr);
         check("low_err", low_err, m_lerr);
         check("stall", stall, m_stall);
         check("err_cnt", err_cnt, m_err);
      end
   end

   task automatic wait_valid(input string tag, output int n_cyc, output int n_herr);
      n_cyc = 0; n_herr = 0;
      do begin
         @(negedge clk);
         n_cyc++;
         if (high_err) n_herr++;
      end while (!meas_valid && n_cyc < 400);
      check({tag, "_valid"}, meas_valid, 1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_meas_high"}, meas_high, 0);
      check({tag, "_meas_low"}, meas_low, 0);
      check({tag, "_meas_valid"}, meas_valid, 0);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
   endtask

   initial begin
      int n, nh, e0, off;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_cleared("rst");
      #2 rst_n = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);
      en = 1'b1; gen_on = 1'b1;

      // 5/5 nominal
      repeat (3) wait_valid("a_sync", n, nh);
      wait_valid("a", n, nh);
      check("a_period", n, 10);
      check("a_meas_high", meas_high, 5);
      check("a_meas_low", meas_low, 5);
      check("a_err_cnt", err_cnt, 0);

      // 7/3: both phases out of window
      hi_len = 7; lo_len = 3;
      repeat (3) wait_valid("b_sync", n, nh);
      e0 = int'(err_cnt);
      wait_valid("b", n, nh);
      check("b_meas_high", meas_high, 7);
      check("b_meas_low", meas_low, 3);
      check("b_high_err_pulses", nh, 1);
      check("b_low_err", low_err, 1);
      check("b_err_cnt", err_cnt, e0 + 2);

      // 6/4: window boundary, still good
      hi_len = 6; lo_len = 4;
      repeat (3) wait_valid("c_sync", n, nh);
      e0 = int'(err_cnt);
      wait_valid("c", n, nh);
      check("c_meas_high", meas_high, 6);
      check("c_meas_low", meas_low, 4);
      check("c_high_err_pulses", nh, 0);
      check("c_err_cnt", err_cnt, e0);

      // Stopped clock
      gen_on = 1'b0;
      e0 = int'(err_cnt);
`ifdef CLK_MON_STALL_EN
      n = 0;
      do begin @(negedge clk); n++; end while (!stall && n < 300);
      check("d_stall_set", stall, 1);
      check("d_stall_delay", cyc, last_fall_cyc + 3 + TIMEOUT);
      check("d_stall_err_cnt", err_cnt, e0 + 1);
      repeat (30) @(negedge clk);
      hi_len = 5; lo_len = 5; gen_on = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (stall && n < 60);
      check("d_stall_clear", stall, 0);
      check("d_restart_no_valid", meas_valid, 0);
      wait_valid("d_restart", n, nh);
      check("d_restart_high", meas_high, 5);
      check("d_restart_low", meas_low, 5);
`else
      repeat (100) @(negedge clk);
      hi_len = 5; lo_len = 5; gen_on = 1'b1;
      wait_valid("d_restart", n, nh);
      check("d_long_low", meas_low, last_rise_cyc - last_fall_cyc);
      check("d_long_low_err", low_err, 1);
      check("d_no_stall", stall, 0);
`endif

      // Reset mid-high phase (mon_clk is high right after a valid)
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check_cleared("e_rst");
      #2 rst_n = 1'b1;
      wait_valid("e", n, nh);
      check("e_high_err_pulses", nh, 0);
      check("e_meas_high", meas_high, 5);
      check("e_meas_low", meas_low, 5);
      check("e_err_cnt", err_cnt, 0);

      // err_clr coinciding with a low_err pulse
      hi_len = 7; lo_len = 3;
      repeat (3) wait_valid("f_sync", n, nh);
      n = 0;
      do begin @(negedge clk); n++; end while (cyc != last_rise_cyc + 2 && n < 50);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("f_low_err", low_err, 1);
      check("f_err_cnt", err_cnt, 1);

      // Saturation: 1/1 phases give two errors per 2 cycles
      hi_len = 1; lo_len = 1;
      repeat (360) @(negedge clk);
      check("g_err_sat", err_cnt, 255);

      // Randomized phases, enable drops and clears
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      gen_rand = 1'b1; off = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (off > 0) begin
            off--;
            if (off == 0) en = 1'b1;
         end else if ($urandom_range(0, 99) == 0) begin
            en = 1'b0; off = int'($urandom_range(1, 6));
         end
         err_clr = ($urandom_range(0, 29) == 0);
      end
      en = 1'b1; err_clr = 1'b0;
      repeat (5) @(negedge clk);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
